// File: rtl/s7_lvds_pkg.sv
// s7_lvds_pkg: shared types and constants for the s7_lvds_tx serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package s7_lvds_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // pattern_sel encodings (only meaningful with S7_LVDS_TX_PATTERN_EN)
  localparam logic [1:0] PAT_DATA = 2'd0;
  localparam logic [1:0] PAT_RAMP = 2'd1;
  localparam logic [1:0] PAT_ALT  = 2'd2;
  localparam logic [1:0] PAT_ONES = 2'd3;

  // word sent on every lane when no sample is offered at a load slot
  localparam logic [7:0] IDLE_WORD_DEF = 8'hA5;

endpackage

// File: rtl/s7_lvds_tx_if.sv
// s7_lvds_tx_if: parallel sample-word handshake into the serializer.
// Latency: n/a (wires only).
// Backpressure: s_ready is driven by the serializer; a word moves when s_valid && s_ready.
// Ports: s_data (lane k at [k*BITS +: BITS]), s_valid, s_ready.
interface s7_lvds_tx_if #(
  parameter int N_LANES = 2,
  parameter int BITS    = 8
);
  logic [N_LANES*BITS-1:0] s_data;
  logic                    s_valid;
  logic                    s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/s7_lvds_tx_lane.sv
// s7_lvds_tx_lane: one lane's BITS-wide load/shift register, MSB first.
// Latency: a loaded word's MSB is on msb the cycle after load.
// Backpressure: none; load wins over shift.
// Ports: clk, rst_n (async active low), load, shift, word (parallel in), msb (serial out).
module s7_lvds_tx_lane #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            shift,
  input  logic [BITS-1:0] word,
  output logic            msb
);

  logic [BITS-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= word;
    end else if (shift) begin
      sr <= {sr[BITS-2:0], 1'b0};
    end
  end

  assign msb = sr[BITS-1];

endmodule

// File: rtl/s7_lvds_tx.sv
// s7_lvds_tx: fabric serializer emulating a multi-lane LVDS ADC output (dco, fr, lanes).
// Latency: a word accepted in cycle t shows its MSB at t+1 and its LSB at t+BITS.
// Backpressure: s_ready is a fixed once-per-word load slot; a missing word becomes IDLE_WORD.
// Ports: sys_clk, sys_rst_n (async active low), enable (run request), s_if (slave word
//   handshake), tx_slip (one-bit frame slip pulse), dco (bit clock), fr (frame marker),
//   lane_out (serial lanes), busy (in RUN), underflow_cnt (saturating IDLE_WORD count).
// Optional: macro S7_LVDS_TX_PATTERN_EN adds pattern_sel (ramp / 0x55-0xAA / all ones).
module s7_lvds_tx
  import s7_lvds_pkg::*;
#(
  parameter int              N_LANES   = 2,
  parameter int              BITS      = 8,
  parameter logic [BITS-1:0] IDLE_WORD = BITS'(IDLE_WORD_DEF),
  parameter int              CNT_W     = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               enable,
  s7_lvds_tx_if.slave        s_if,
  input  logic               tx_slip,
`ifdef S7_LVDS_TX_PATTERN_EN
  input  logic [1:0]         pattern_sel,
`endif
  output logic               dco,
  output logic               fr,
  output logic [N_LANES-1:0] lane_out,
  output logic               busy,
  output logic [CNT_W-1:0]   underflow_cnt
);

  localparam int            CW   = $clog2(BITS);
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);
  localparam logic [CW-1:0] HALF = CW'(BITS / 2);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n, cnt_inc;
  logic            dco_n, fr_n;
  logic            slip_pend, slip_pend_n;
  logic            last_bit, slip_hold, load_slot, shift;
  logic            take_input;
  logic [BITS-1:0] lane_word [N_LANES];

  // cnt is the index of the bit currently on lane_out.
  assign last_bit  = (state == RUN) && (cnt == LAST);
  // The LSB stays on the lanes one extra cycle; the load slot moves one cycle later.
  assign slip_hold = last_bit && slip_pend;
  // Gated by reset so no handshake is offered while the block is held in reset.
  assign load_slot = sys_rst_n && enable && ((state == IDLE) || (last_bit && !slip_hold));
  assign cnt_inc   = cnt + CW'(1);
  assign busy      = (state == RUN);

`ifdef S7_LVDS_TX_PATTERN_EN
  logic [BITS-1:0] ramp;
  logic            alt_hi;
  logic [BITS-1:0] pat_word;

  assign take_input = (pattern_sel == PAT_DATA);

  always_comb begin
    pat_word = '1;
    case (pattern_sel)
      PAT_RAMP: pat_word = ramp;
      PAT_ALT:  pat_word = alt_hi ? {(BITS/2){2'b10}} : {(BITS/2){2'b01}};
      default:  pat_word = '1;
    endcase
  end

  // Pattern state advances only on words of its own pattern.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ramp   <= '0;
      alt_hi <= 1'b0;
    end else if (load_slot) begin
      if (pattern_sel == PAT_RAMP) ramp <= ramp + BITS'(1);
      if (pattern_sel == PAT_ALT)  alt_hi <= !alt_hi;
    end
  end
`else
  assign take_input = 1'b1;
`endif

  assign s_if.s_ready = load_slot && take_input;

  always_comb begin
    for (int k = 0; k < N_LANES; k++) begin
      lane_word[k] = s_if.s_valid ? s_if.s_data[k*BITS +: BITS] : IDLE_WORD;
`ifdef S7_LVDS_TX_PATTERN_EN
      if (!take_input) lane_word[k] = pat_word;
`endif
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    dco_n       = dco;
    fr_n        = fr;
    shift       = 1'b0;
    slip_pend_n = slip_pend | tx_slip;
    if (slip_hold) begin
      // Frozen cycle: outputs and cnt hold, the pending slip is consumed, new pulses dropped.
      slip_pend_n = 1'b0;
    end else if (load_slot) begin
      state_n = RUN;
      cnt_n   = '0;
      dco_n   = 1'b1;
      fr_n    = 1'b1;
    end else if (state == RUN) begin
      shift = 1'b1;
      if (last_bit) begin
        state_n = IDLE;
        cnt_n   = '0;
        dco_n   = 1'b0;
        fr_n    = 1'b0;
      end else begin
        cnt_n = cnt_inc;
        dco_n = !dco;
        fr_n  = (cnt_inc < HALF);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dco       <= 1'b0;
      fr        <= 1'b0;
      slip_pend <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      dco       <= dco_n;
      fr        <= fr_n;
      slip_pend <= slip_pend_n;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      underflow_cnt <= '0;
    end else if (load_slot && take_input && !s_if.s_valid && (underflow_cnt != '1)) begin
      underflow_cnt <= underflow_cnt + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    s7_lvds_tx_lane #(.BITS(BITS)) u_lane (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .load  (load_slot),
      .shift (shift),
      .word  (lane_word[k]),
      .msb   (lane_out[k])
    );
  end

endmodule

// File: tb/tb_s7_lvds_tx.sv
// tb_s7_lvds_tx: self-checking bench for s7_lvds_tx (2 lanes x 8 bits).
// Latency: n/a.
// Backpressure: n/a.
module tb_s7_lvds_tx;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       enable;
  logic       tx_slip;
  logic       dco, fr, busy;
  logic [1:0] lane_out;
  logic [15:0] underflow_cnt;
  logic       dco2, fr2, busy2;
  logic [1:0] lane_out2;
  logic [1:0] uf2_out;

  s7_lvds_tx_if #(.N_LANES(2), .BITS(8)) s_if ();
  s7_lvds_tx_if #(.N_LANES(2), .BITS(8)) s_if2 ();
  assign s_if2.s_data  = s_if.s_data;
  assign s_if2.s_valid = s_if.s_valid;

`ifdef S7_LVDS_TX_PATTERN_EN
  logic [1:0] pattern_sel = 2'd0;
`endif

  s7_lvds_tx u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .s_if(s_if),
    .tx_slip(tx_slip),
`ifdef S7_LVDS_TX_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .dco(dco), .fr(fr), .lane_out(lane_out), .busy(busy), .underflow_cnt(underflow_cnt)
  );

  // Narrow-counter copy, used only for the saturation check.
  s7_lvds_tx #(.CNT_W(2)) u_dut2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .s_if(s_if2),
    .tx_slip(tx_slip),
`ifdef S7_LVDS_TX_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .dco(dco2), .fr(fr2), .lane_out(lane_out2), .busy(busy2), .underflow_cnt(uf2_out)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a queue of future output beats ----------------
  typedef struct packed {
    logic [1:0] lanes;
    logic       fr;
    logic       dco;
    logic       busy;
  } beat_t;

  beat_t cur;
  beat_t q[$];
  bit    pend;
  int    uf;

  always @(negedge sys_clk) begin : model
    beat_t      b;
    logic [7:0] w;
    bit         rdy_exp;
    if (!sys_rst_n) begin
      cur  = '0;
      q.delete();
      pend = 0;
      uf   = 0;
    end else begin
      chk("m_beat", 32'({lane_out, fr, dco, busy}), 32'(cur));
      chk("m_uf", 32'(underflow_cnt), 32'(uf));
      chk("m_uf_sat", 32'(uf2_out), (uf > 3) ? 32'd3 : 32'(uf));
      rdy_exp = 0;
      if (q.size() == 0 && cur.busy && pend) begin
        q.push_back(cur);          // word's last bit repeated once
        pend = 0;
      end else begin
        pend = pend | tx_slip;
        if (q.size() == 0) begin
          if (enable) begin
            rdy_exp = 1;
            if (!s_if.s_valid) uf++;
            for (int i = 0; i < 8; i++) begin
              b.busy = 1'b1;
              b.fr   = (i < 4);
              b.dco  = (i % 2 == 0);
              for (int k = 0; k < 2; k++) begin
                w = s_if.s_valid ? s_if.s_data[k*8 +: 8] : 8'hA5;
                b.lanes[k] = w[7-i];
              end
              q.push_back(b);
            end
          end else begin
            q.push_back('0);
          end
        end
      end
      chk("m_rdy", 32'(s_if.s_ready), 32'(rdy_exp));
      cur = q.pop_front();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit en, input bit vld, input logic [15:0] d, input bit slip);
    enable = en; s_if.s_valid = vld; s_if.s_data = d; tx_slip = slip;
  endtask

  task automatic step();
    @(posedge sys_clk); #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    enable = 0; s_if.s_valid = 0; tx_slip = 0;
    @(negedge sys_clk);
    while (busy && n < 40) begin
      step(); @(negedge sys_clk); n++;
    end
    chk(name, 32'(busy), 32'd0);
    step();
  endtask

  // cycles from the current accept to the next s_ready, with slip pulses at p1/p2
  task automatic gap(input int p1, input int p2, output int n);
    bit got;
    got = 0; n = 1;
    step();
    while (!got && n < 20) begin
      tx_slip = (n == p1) || (n == p2);
      @(negedge sys_clk);
      if (s_if.s_ready) got = 1;
      else begin step(); n++; end
    end
    tx_slip = 0;
  endtask

  typedef struct {
    bit          en;
    bit          vld;
    logic [15:0] dat;
    logic [5:0]  exp;  // {s_ready, lane_out[1:0], fr, dco, busy}
  } vec_t;
  vec_t tbl[10];

  initial begin
    int nrdy, badpos, n;
    bit b8, z9;
    // first word 16'h3C81 straight out of reset: lane0=0x81, lane1=0x3C
    tbl[0] = '{1, 1, 16'h3C81, 6'b100000};
    tbl[1] = '{1, 1, 16'h3C81, 6'b001111};
    tbl[2] = '{1, 1, 16'h3C81, 6'b000101};
    tbl[3] = '{1, 1, 16'h3C81, 6'b010111};
    tbl[4] = '{1, 1, 16'h3C81, 6'b010101};
    tbl[5] = '{1, 1, 16'h3C81, 6'b010011};
    tbl[6] = '{1, 1, 16'h3C81, 6'b010001};
    tbl[7] = '{1, 1, 16'h3C81, 6'b000011};
    tbl[8] = '{0, 1, 16'h3C81, 6'b001001};
    tbl[9] = '{0, 1, 16'h3C81, 6'b000000};

    sys_rst_n = 0;
    drive(1, 1, 16'h3C81, 0);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_outs", 32'({s_if.s_ready, lane_out, fr, dco, busy}), 32'd0);
    chk("rst_uf", 32'(underflow_cnt), 32'd0);
    step();

    for (int i = 0; i < 10; i++) begin
      if (i == 0) sys_rst_n = 1;
      drive(tbl[i].en, tbl[i].vld, tbl[i].dat, 0);
      @(negedge sys_clk);
      chk($sformatf("tbl%0d", i), 32'({s_if.s_ready, lane_out, fr, dco, busy}), 32'(tbl[i].exp));
      step();
    end

    // back-to-back words
    drive(1, 1, 16'h0102, 0);
    nrdy = 0; badpos = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge sys_clk);
      if (s_if.s_ready) begin
        nrdy++;
        if (c % 8 != 0) badpos++;
      end
      step();
      if (nrdy >= 1) s_if.s_data = 16'h0304;
    end
    chk("b2b_rdy_cnt", 32'(nrdy), 32'd3);
    chk("b2b_rdy_pos", 32'(badpos), 32'd0);
    chk("b2b_uf", 32'(underflow_cnt), 32'd0);
    wait_idle("b2b_idle");

    // underflow: five IDLE_WORD substitutions
    drive(1, 0, 16'h0000, 0);
    repeat (40) step();
    wait_idle("uf_idle");
    chk("uf_count", 32'(underflow_cnt), 32'd5);
    chk("uf_sat", 32'(uf2_out), 32'd3);

    // slip: two pulses in one word shift the frame by a single bit
    drive(1, 1, 16'($urandom), 0);
    @(negedge sys_clk);
    chk("slip_rdy0", 32'(s_if.s_ready), 32'd1);
    gap(2, 4, n);
    chk("slip_gap1", 32'(n), 32'd9);
    gap(-1, -1, n);
    chk("slip_gap2", 32'(n), 32'd8);
    wait_idle("slip_idle");

    // enable dropped at cnt=3
    drive(1, 1, 16'($urandom), 0);
    @(negedge sys_clk);
    chk("endrop_rdy0", 32'(s_if.s_ready), 32'd1);
    repeat (4) step();
    enable = 0;
    nrdy = 0; b8 = 0; z9 = 0;
    for (int c = 4; c < 13; c++) begin
      @(negedge sys_clk);
      if (s_if.s_ready) nrdy++;
      if (c == 8) b8 = busy;
      if (c == 9) z9 = ({lane_out, fr, dco, busy} == 5'd0);
      step();
    end
    chk("endrop_rdy", 32'(nrdy), 32'd0);
    chk("endrop_lsb_busy", 32'(b8), 32'd1);
    chk("endrop_idle_zero", 32'(z9), 32'd1);

    // randomized traffic with one mid-word reset
    for (int c = 0; c < 800; c++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 16'($urandom),
            $urandom_range(0, 19) == 0);
      if (c == 403) sys_rst_n = 0;
      if (c == 405) sys_rst_n = 1;
      step();
    end
    wait_idle("rand_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
